// File: rtl/platform_scheduler.sv
// Platform table owner: per-frame scroll/respawn sequencer plus per-pixel platform hit lookup.
// Optional macro RANDOM_RESPAWN_EN selects LFSR-driven respawn X; default keeps the slot's X.
module platform_scheduler #(
  parameter int NUM_PLAT = 8,
  parameter int PLAT_W   = 16,
  parameter int PLAT_H   = 4,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic [9:0] scroll_dy,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       platform_on,
  output logic [3:0] platform_col,
  output logic [1:0] platform_row,
  output logic       busy,
  output logic       overrun
);

  localparam int IDX_W = $clog2(NUM_PLAT);

  typedef enum logic [1:0] {IDLE, SCROLL, COMMIT} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [9:0]       dyLat_q;
  logic             busy_q;
  logic             overrun_q;
  logic [9:0]       workX_q [NUM_PLAT];
  logic [10:0]      workY_q [NUM_PLAT];
  logic [9:0]       dispX_q [NUM_PLAT];
  logic [10:0]      dispY_q [NUM_PLAT];

  logic [9:0]  clampDy_d;
  logic [10:0] sumY_d;
  logic        wrap_d;
  logic [10:0] newY_d;
  logic [9:0]  newX_d;
  logic [9:0]  respawnX_d;

`ifdef RANDOM_RESPAWN_EN
  logic [15:0] lfsr_q;
  logic [9:0]  lfsrX_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_comb begin
    lfsrX_d    = lfsr_q[9:0];
    respawnX_d = (lfsrX_d >= 10'(SCREEN_W - PLAT_W)) ? (lfsrX_d - 10'd512) : lfsrX_d;
  end
`else
  always_comb begin
    respawnX_d = workX_q[idx_q];
  end
`endif

  always_comb begin
    clampDy_d = (scroll_dy > 10'(SCREEN_H - 1)) ? 10'(SCREEN_H - 1) : scroll_dy;
    sumY_d    = workY_q[idx_q] + {1'b0, dyLat_q};
    wrap_d    = (sumY_d >= 11'(SCREEN_H));
    newY_d    = wrap_d ? (sumY_d - 11'(SCREEN_H)) : sumY_d;
    newX_d    = wrap_d ? respawnX_d : workX_q[idx_q];
  end

  // The display table is only written in COMMIT, so lookup never sees a half-scrolled frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dyLat_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        workX_q[i] <= 10'((SCREEN_W / NUM_PLAT) * i);
        workY_q[i] <= 11'((SCREEN_H / NUM_PLAT) * i);
        dispX_q[i] <= 10'((SCREEN_W / NUM_PLAT) * i);
        dispY_q[i] <= 11'((SCREEN_H / NUM_PLAT) * i);
      end
    end else begin
      if (frame_start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            dyLat_q <= clampDy_d;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCROLL;
          end
        end
        SCROLL: begin
          workY_q[idx_q] <= newY_d;
          workX_q[idx_q] <= newX_d;
          if (idx_q == IDX_W'(NUM_PLAT - 1)) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_PLAT; i++) begin
            dispX_q[i] <= workX_q[i];
            dispY_q[i] <= workY_q[i];
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic        hit_d;
  logic [3:0]  hitCol_d;
  logic [1:0]  hitRow_d;
  logic [10:0] xOff_d;
  logic [10:0] yOff_d;

  // Scan from the top slot down so the lowest matching index is the one left standing.
  always_comb begin
    hit_d    = 1'b0;
    hitCol_d = '0;
    hitRow_d = '0;
    xOff_d   = '0;
    yOff_d   = '0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      xOff_d = {1'b0, DrawX} - {1'b0, dispX_q[i]};
      yOff_d = {1'b0, DrawY} - dispY_q[i];
      if (({1'b0, DrawX} >= {1'b0, dispX_q[i]}) && (xOff_d < 11'(PLAT_W)) &&
          ({1'b0, DrawY} >= dispY_q[i]) && (yOff_d < 11'(PLAT_H))) begin
        hit_d    = 1'b1;
        hitCol_d = xOff_d[3:0];
        hitRow_d = yOff_d[1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      platform_on  <= 1'b0;
      platform_col <= '0;
      platform_row <= '0;
    end else begin
      platform_on  <= hit_d;
      platform_col <= hitCol_d;
      platform_row <= hitRow_d;
    end
  end

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler: reset ladder, scroll, wrap, clamp, overrun, mid-sequence reset.
module tb_platform_scheduler;

  logic       Clk;
  logic       Reset_n;
  logic       frame_start;
  logic [9:0] scroll_dy;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       platform_on;
  logic [3:0] platform_col;
  logic [1:0] platform_row;
  logic       busy;
  logic       overrun;

  int checkCount;
  int failCount;
  int busyCycles;

  platform_scheduler dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .scroll_dy    (scroll_dy),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .platform_on  (platform_on),
    .platform_col (platform_col),
    .platform_row (platform_row),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge Clk);
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input int expOn, input int expCol, input int expRow);
    applyStimulus(x, y);
    checkOutput({tag, ".on"}, int'(platform_on), expOn);
    checkOutput({tag, ".col"}, int'(platform_col), expCol);
    checkOutput({tag, ".row"}, int'(platform_row), expRow);
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Pulses frame_start, optionally re-pulses at cycle T+secondAt, and counts busy cycles.
  task automatic runFrame(input int dy, input int secondAt, input int dy2, output int cycles);
    @(negedge Clk);
    frame_start = 1'b1;
    scroll_dy   = 10'(dy);
    cycles      = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      frame_start = (k == secondAt);
      if (k == secondAt) scroll_dy = 10'(dy2);
      if (busy) cycles++;
      else if (cycles > 0) break;
    end
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount  = 0;
    failCount   = 0;
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    scroll_dy   = '0;
    DrawX       = '0;
    DrawY       = '0;

    repeat (2) @(negedge Clk);
    checkOutput("rst.on", int'(platform_on), 0);
    checkOutput("rst.col", int'(platform_col), 0);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.overrun", int'(overrun), 0);
    Reset_n = 1'b1;

    for (int x = 80; x <= 95; x++) begin
      applyStimulus(x, 60);
      checkOutput($sformatf("ladder.on%0d", x), int'(platform_on), 1);
      checkOutput($sformatf("ladder.col%0d", x), int'(platform_col), x - 80);
    end
    probe("ladder.x96", 96, 60, 0, 0, 0);
    probe("ladder.slot7", 575, 423, 1, 15, 3);
    checkOutput("ladder.busy", int'(busy), 0);
    checkOutput("ladder.overrun", int'(overrun), 0);

    runFrame(10, 0, 0, busyCycles);
    checkOutput("scroll.busyCycles", busyCycles, 9);
    for (int y = 70; y <= 73; y++) begin
      probe($sformatf("scroll.y%0d", y), 80, y, 1, 0, y - 70);
    end
    probe("scroll.y60", 80, 60, 0, 0, 0);
    probe("scroll.y74", 80, 74, 0, 0, 0);
    probe("scroll.slot0", 3, 10, 1, 3, 0);
    checkOutput("scroll.overrun", int'(overrun), 0);

    doReset();
    runFrame(60, 0, 0, busyCycles);
    checkOutput("wrap.busyCycles", busyCycles, 9);
    probe("wrap.slot7a", 560, 0, 1, 0, 0);
    probe("wrap.slot7b", 575, 3, 1, 15, 3);
    probe("wrap.slot0", 0, 60, 1, 0, 0);
    probe("wrap.slot0old", 0, 0, 0, 0, 0);
    probe("wrap.slot1", 82, 121, 1, 2, 1);

    doReset();
    runFrame(1000, 0, 0, busyCycles);
    probe("clamp.slot0", 5, 479, 1, 5, 0);
    probe("clamp.slot0old", 0, 0, 0, 0, 0);
    probe("clamp.slot1", 81, 62, 1, 1, 3);

    doReset();
    runFrame(10, 3, 100, busyCycles);
    checkOutput("overrun.flag", int'(overrun), 1);
    checkOutput("overrun.busyCycles", busyCycles, 9);
    probe("overrun.slot1", 80, 70, 1, 0, 0);
    probe("overrun.slot2", 160, 130, 1, 0, 0);
    repeat (3) @(negedge Clk);
    checkOutput("overrun.idle", int'(busy), 0);
    checkOutput("overrun.sticky", int'(overrun), 1);

    doReset();
    @(negedge Clk);
    frame_start = 1'b1;
    scroll_dy   = 10'd100;
    DrawX       = 10'd700;
    DrawY       = 10'd700;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      frame_start = 1'b0;
    end
    checkOutput("midrst.busyBefore", int'(busy), 1);
    Reset_n = 1'b0;
    #1;
    checkOutput("midrst.busy", int'(busy), 0);
    checkOutput("midrst.overrun", int'(overrun), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    probe("midrst.slot1", 80, 60, 1, 0, 0);
    probe("midrst.slot4", 327, 242, 1, 7, 2);
    probe("midrst.slot7", 560, 420, 1, 0, 0);

    runFrame(0, 0, 0, busyCycles);
    checkOutput("dy0.busyCycles", busyCycles, 9);
    probe("dy0.slot2", 165, 121, 1, 5, 1);
    probe("dy0.slot0", 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
